// File: rtl/tcam_rsp_buffer.sv
// Response FIFO downstream of tcam: captures each match result, hands it to the
// consumer over valid/ready, drops and counts results that arrive while full.
module tcam_rsp_buffer #(
  parameter int CAM_WIDTH = 32,
  parameter int CAM_DEPTH = 16,
  parameter int RSP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           index_rdy,
  input  logic [$clog2(CAM_DEPTH)-1:0]   index_o,
  input  logic [CAM_WIDTH-1:0]           data_o,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(CAM_DEPTH)-1:0]   rsp_index,
  output logic [CAM_WIDTH-1:0]           rsp_data,
  output logic [$clog2(RSP_DEPTH):0]     level,
  output logic                           almost_full,
  output logic [15:0]                    drop_cnt,
  output logic [31:0]                    hit_cnt,
  input  logic                           clr_cnt
);

  localparam int CAM_INDEX_WIDTH = $clog2(CAM_DEPTH);
  localparam int LVL_WIDTH       = $clog2(RSP_DEPTH) + 1;
  localparam int PTR_W           = $clog2(RSP_DEPTH);

  localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(RSP_DEPTH);
  localparam logic [LVL_WIDTH-1:0] AF_LVL   = LVL_WIDTH'(RSP_DEPTH - 1);

  // Handshake: a transfer happens on a rising edge where rsp_valid && rsp_ready;
  // the head (rsp_index/rsp_data) stays stable while rsp_valid && !rsp_ready.

  logic [CAM_INDEX_WIDTH-1:0] mem_index [RSP_DEPTH];
  logic [CAM_WIDTH-1:0]       mem_data  [RSP_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;

  logic full;
  logic push;
  logic pop;
  logic drop;

  assign full      = (level == FULL_LVL);
  assign rsp_valid = (level != '0);
  assign pop       = rsp_valid && rsp_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = index_rdy && (!full || pop);
  assign drop      = index_rdy && full && !pop;

  assign rsp_index   = mem_index[rd_ptr];
  assign rsp_data    = mem_data[rd_ptr];
  assign almost_full = (level >= AF_LVL);

  // Storage is intentionally not reset; only pointers and level are.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_index[wr_ptr] <= index_o;
      mem_data[wr_ptr]  <= data_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_WIDTH'(1);
        2'b01:   level <= level - LVL_WIDTH'(1);
        default: level <= level;
      endcase
    end
  end

  // Clear takes priority over a coincident push/drop.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      drop_cnt <= '0;
      hit_cnt  <= '0;
    end else begin
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (push) hit_cnt <= hit_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_tcam_rsp_buffer.sv
// Directed bench for tcam_rsp_buffer with RSP_DEPTH=4, CAM_WIDTH=32, CAM_DEPTH=16.
module tb_tcam_rsp_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        index_rdy;
  logic [3:0]  index_o;
  logic [31:0] data_o;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_index;
  logic [31:0] rsp_data;
  logic [2:0]  level;
  logic        almost_full;
  logic [15:0] drop_cnt;
  logic [31:0] hit_cnt;
  logic        clr_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tcam_rsp_buffer #(.CAM_WIDTH(32), .CAM_DEPTH(16), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .index_rdy(index_rdy), .index_o(index_o), .data_o(data_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_index(rsp_index),
    .rsp_data(rsp_data), .level(level), .almost_full(almost_full),
    .drop_cnt(drop_cnt), .hit_cnt(hit_cnt), .clr_cnt(clr_cnt)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; index_rdy = 1'b0; index_o = '0; data_o = '0;
    rsp_ready = 1'b0; clr_cnt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b exp 0", rsp_valid); end
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", level); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af got %0b exp 0", almost_full); end
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    vectors++; if (hit_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_hit got %0d exp 0", hit_cnt); end
  endtask

  task automatic test_pass_through();
    rsp_ready = 1'b1;
    index_rdy = 1'b1; index_o = 4'h3; data_o = 32'hDEADBEEF;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL pt_no_bypass got %0b exp 0", rsp_valid); end
    tick();
    index_rdy = 1'b0;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL pt_valid got %0b exp 1", rsp_valid); end
    vectors++; if (rsp_index !== 4'h3) begin miscompares++; $display("FAIL pt_index got %0h exp 3", rsp_index); end
    vectors++; if (rsp_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL pt_data got %08h exp DEADBEEF", rsp_data); end
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL pt_valid_after got %0b exp 0", rsp_valid); end
    vectors++; if (hit_cnt !== 32'd1) begin miscompares++; $display("FAIL pt_hit got %0d exp 1", hit_cnt); end
  endtask

  task automatic test_fill_overflow_drain();
    logic [2:0] exp_lvl;
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      index_rdy = 1'b1; index_o = 4'(i); data_o = 32'hA000_0000 + 32'(i);
      tick();
      exp_lvl = (i < 4) ? 3'(i + 1) : 3'd4;
      vectors++; if (level !== exp_lvl) begin miscompares++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, exp_lvl); end
      vectors++; if (almost_full !== (exp_lvl >= 3'd3)) begin miscompares++; $display("FAIL fill_af[%0d] got %0b exp %0b", i, almost_full, exp_lvl >= 3'd3); end
    end
    index_rdy = 1'b0;
    vectors++; if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL fill_drop got %0d exp 2", drop_cnt); end
    vectors++; if (hit_cnt !== 32'd4) begin miscompares++; $display("FAIL fill_hit got %0d exp 4", hit_cnt); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (rsp_valid !== 1'b1 || rsp_index !== 4'(i)) begin miscompares++; $display("FAIL drain_head[%0d] got v=%0b idx=%0h exp v=1 idx=%0h", i, rsp_valid, rsp_index, i); end
      vectors++; if (rsp_data !== 32'hA000_0000 + 32'(i)) begin miscompares++; $display("FAIL drain_data[%0d] got %08h exp %08h", i, rsp_data, 32'hA000_0000 + 32'(i)); end
      tick();
    end
    rsp_ready = 1'b0;
    vectors++; if (level !== 3'd0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got lvl=%0d v=%0b exp lvl=0 v=0", level, rsp_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_order [4];
    exp_order = '{4'd1, 4'd2, 4'd3, 4'd7};
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      index_rdy = 1'b1; index_o = 4'(i); data_o = 32'hB000_0000 + 32'(i);
      tick();
    end
    vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL fpp_full got %0d exp 4", level); end
    index_o = 4'h7; data_o = 32'hB000_0007; rsp_ready = 1'b1;
    vectors++; if (rsp_index !== 4'd0) begin miscompares++; $display("FAIL fpp_head0 got %0h exp 0", rsp_index); end
    tick();
    index_rdy = 1'b0; rsp_ready = 1'b0;
    vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL fpp_level got %0d exp 4", level); end
    vectors++; if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL fpp_drop got %0d exp 2", drop_cnt); end
    vectors++; if (hit_cnt !== 32'd9) begin miscompares++; $display("FAIL fpp_hit got %0d exp 9", hit_cnt); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (rsp_valid !== 1'b1 || rsp_index !== exp_order[i]) begin miscompares++; $display("FAIL fpp_order[%0d] got v=%0b idx=%0h exp idx=%0h", i, rsp_valid, rsp_index, exp_order[i]); end
      tick();
    end
    rsp_ready = 1'b0;
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL fpp_empty got %0d exp 0", level); end
  endtask

  task automatic test_counters();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      index_rdy = 1'b1; index_o = 4'(i + 8); data_o = 32'hC000_0000 + 32'(i);
      tick();
    end
    for (int i = 0; i < 70000; i++) tick();
    vectors++; if (drop_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL drop_sat got %04h exp FFFF", drop_cnt); end
    vectors++; if (hit_cnt !== 32'd13) begin miscompares++; $display("FAIL sat_hit got %0d exp 13", hit_cnt); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0; index_rdy = 1'b0;
    vectors++; if (drop_cnt !== 16'd0 || hit_cnt !== 32'd0) begin miscompares++; $display("FAIL clr_with_drop got drop=%0d hit=%0d exp 0/0", drop_cnt, hit_cnt); end
    tick();
    vectors++; if (drop_cnt !== 16'd0 || level !== 3'd4) begin miscompares++; $display("FAIL clr_hold got drop=%0d lvl=%0d exp 0/4", drop_cnt, level); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    vectors++; if (level !== 3'd3) begin miscompares++; $display("FAIL rm_pre_level got %0d exp 3", level); end
    rst = 1'b1; index_rdy = 1'b1; index_o = 4'h9; data_o = 32'h9999_9999;
    tick();
    rst = 1'b0; index_rdy = 1'b0;
    vectors++; if (level !== 3'd0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_level got lvl=%0d v=%0b exp 0/0", level, rsp_valid); end
    vectors++; if (hit_cnt !== 32'd0 || drop_cnt !== 16'd0) begin miscompares++; $display("FAIL rm_cnt got hit=%0d drop=%0d exp 0/0", hit_cnt, drop_cnt); end
    index_rdy = 1'b1; index_o = 4'h5; data_o = 32'h0000_0055;
    tick();
    index_rdy = 1'b0;
    vectors++; if (rsp_valid !== 1'b1 || rsp_index !== 4'h5 || rsp_data !== 32'h55) begin miscompares++; $display("FAIL rm_first got v=%0b idx=%0h data=%08h exp 1/5/00000055", rsp_valid, rsp_index, rsp_data); end
    vectors++; if (level !== 3'd1 || hit_cnt !== 32'd1) begin miscompares++; $display("FAIL rm_after got lvl=%0d hit=%0d exp 1/1", level, hit_cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass_through();
    test_fill_overflow_drain();
    test_full_push_pop();
    test_counters();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
